// File: rtl/activation_unit.sv
// Registered activation stage: ReLU, sigmoid (full ROM or half symmetric ROM) and pass-through, 1-clk latency.
// Optional feature macro: ACT_HALF_ROM_EN builds the half-size sigmoid ROM for act_sel=2'b10.
module activation_unit #(
    parameter int DATA_WIDTH       = 16,
    parameter int FRAC_WIDTH       = 12,
    parameter int WEIGHT_INT_WIDTH = 4,
    parameter int SIG_SIZE         = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [1:0]              act_sel,
    input  logic [2*DATA_WIDTH-1:0] sum,
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    out_valid
);

    localparam int SW        = 2 * DATA_WIDTH;
    localparam int XF        = 2 * FRAC_WIDTH + SIG_SIZE + WEIGHT_INT_WIDTH - SW;
    localparam int ROM_DEPTH = 2 ** SIG_SIZE;
    localparam int IDX_MSB   = SW - 1 - WEIGHT_INT_WIDTH;
    localparam int EW        = FRAC_WIDTH + 1;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    // Rounded sigmoid of x/2^XF in Q.FRAC_WIDTH, evaluated only at elaboration.
    function automatic logic [EW-1:0] sig_entry(input int x);
        real r;
        real s;
        r = real'(x) / real'(2 ** XF);
        s = 1.0 / (1.0 + $exp(-r));
        return EW'($rtoi(s * real'(2 ** FRAC_WIDTH) + 0.5));
    endfunction

    logic [EW-1:0]         full_rom [ROM_DEPTH];
    logic [DATA_WIDTH-1:0] scaled_s;
    logic [DATA_WIDTH-1:0] relu_s;
    logic [WEIGHT_INT_WIDTH:0] idx_top_s;
    logic [SIG_SIZE-1:0]   sig_x_s;
    logic [EW-1:0]         full_val_s;
    logic [DATA_WIDTH-1:0] out_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_valid_q;
    logic                  unused_s;

    // Address is the two's-complement bit pattern of x.
    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_full_rom
        localparam int XV = (gi >= ROM_DEPTH / 2) ? gi - ROM_DEPTH : gi;
        localparam logic [EW-1:0] ENTRY = sig_entry(XV);
        assign full_rom[gi] = ENTRY;
    end

    assign scaled_s   = sum[FRAC_WIDTH+DATA_WIDTH-1:FRAC_WIDTH];
    assign full_val_s = full_rom[sig_x_s];
    assign unused_s   = ^sum[FRAC_WIDTH-1:0];

    // ReLU with saturation once the integer part no longer fits the output.
    always_comb begin
        if (sum[SW-1]) begin
            relu_s = {DATA_WIDTH{1'b0}};
        end else if (|sum[SW-1:FRAC_WIDTH+DATA_WIDTH-1]) begin
            relu_s = SAT_MAX;
        end else begin
            relu_s = scaled_s;
        end
    end

    // Sigmoid index: clamp when the skipped MSBs are not a sign extension of x.
    always_comb begin
        idx_top_s = sum[SW-1:IDX_MSB];
        if ((&idx_top_s) || !(|idx_top_s)) begin
            sig_x_s = sum[IDX_MSB -: SIG_SIZE];
        end else if (sum[SW-1]) begin
            sig_x_s = {1'b1, {(SIG_SIZE-1){1'b0}}};
        end else begin
            sig_x_s = {1'b0, {(SIG_SIZE-1){1'b1}}};
        end
    end

`ifdef ACT_HALF_ROM_EN
    localparam logic [EW-1:0] ONE_Q = EW'(1) << FRAC_WIDTH;

    logic [EW-1:0]       half_rom [ROM_DEPTH/2];
    logic [SIG_SIZE-1:0] mag_s;
    logic [SIG_SIZE-2:0] half_addr_s;
    logic [EW-1:0]       half_val_s;

    for (genvar gh = 0; gh < ROM_DEPTH / 2; gh++) begin : g_half_rom
        localparam logic [EW-1:0] ENTRY = sig_entry(gh);
        assign half_rom[gh] = ENTRY;
    end

    // sigmoid(-a) = 1 - sigmoid(a); |x| = 2^(SIG_SIZE-1) folds onto the last entry.
    always_comb begin
        if (sig_x_s[SIG_SIZE-1]) begin
            mag_s = ~sig_x_s + {{(SIG_SIZE-1){1'b0}}, 1'b1};
        end else begin
            mag_s = sig_x_s;
        end
        if (mag_s[SIG_SIZE-1]) begin
            half_addr_s = {(SIG_SIZE-1){1'b1}};
        end else begin
            half_addr_s = mag_s[SIG_SIZE-2:0];
        end
        if (sig_x_s[SIG_SIZE-1]) begin
            half_val_s = ONE_Q - half_rom[half_addr_s];
        end else begin
            half_val_s = half_rom[half_addr_s];
        end
    end
`endif

    // Mode select, sampled together with sum.
    always_comb begin
        out_d = out_q;
        case (act_sel)
            2'b00:   out_d = relu_s;
            2'b01:   out_d = DATA_WIDTH'(full_val_s);
`ifdef ACT_HALF_ROM_EN
            2'b10:   out_d = DATA_WIDTH'(half_val_s);
`else
            2'b10:   out_d = DATA_WIDTH'(full_val_s);
`endif
            2'b11:   out_d = scaled_s;
            default: out_d = scaled_s;
        endcase
    end

    // Output register; holds its value between valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= {DATA_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_q <= out_d;
            end else begin
                out_q <= out_q;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_activation_unit.sv
// Scoreboard bench for activation_unit: driver pushes expected outputs, negedge monitor pops and compares.
module tb_activation_unit;

    localparam int XF = 6;

    typedef struct {
        logic [15:0] val;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  act_sel = 2'b00;
    logic [31:0] sum = 32'h0;
    logic [15:0] out;
    logic        out_valid;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          cap_vld = 1'b0;
    bit          cap_rst = 1'b1;
    bit          done = 1'b0;
    logic [15:0] last_out = 16'h0;

    activation_unit #(
        .DATA_WIDTH(16), .FRAC_WIDTH(12), .WEIGHT_INT_WIDTH(4), .SIG_SIZE(10)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .act_sel(act_sel),
        .sum(sum), .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic int sig_e(input int x);
        real s;
        s = 1.0 / (1.0 + $exp(-real'(x) / real'(2 ** XF)));
        return $rtoi(s * 4096.0 + 0.5);
    endfunction

    function automatic int half_e(input int x);
`ifdef ACT_HALF_ROM_EN
        int a;
        a = (x < 0) ? -x : x;
        if (a > 511) a = 511;
        return (x < 0) ? 4096 - sig_e(a) : sig_e(a);
`else
        return sig_e(x);
`endif
    endfunction

    always @(posedge clk) begin
        cap_vld <= in_valid;
        cap_rst <= rst;
    end

    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        ev = cap_vld && !cap_rst;
        checks++;
        if (out_valid !== ev) begin
            failures++;
            $display("FAIL out_valid: got %b expected %b at %0t", out_valid, ev, $time);
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: out=%h with no pending sample at %0t", out, $time);
            end else begin
                e = sb_q.pop_front();
                if (out !== e.val) begin
                    failures++;
                    $display("FAIL %s: out=%h expected=%h at %0t", e.tag, out, e.val, $time);
                end
                last_out = e.val;
            end
        end else begin
            if (cap_rst) last_out = 16'h0;
            checks++;
            if (out !== last_out) begin
                failures++;
                $display("FAIL hold: out=%h expected=%h at %0t", out, last_out, $time);
            end
        end
        if (done) begin
            checks++;
            if (sb_q.size() != 0) begin
                failures++;
                $display("FAIL missing_outputs: pending=%0d expected=0", sb_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic send(input logic [1:0] sel, input logic [31:0] s,
                        input logic [15:0] e, input string tag);
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        act_sel  = sel;
        sum      = s;
        sb_q.push_back('{val: e, tag: tag});
    endtask

    task automatic idle(input logic [31:0] s);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        act_sel  = s[1:0];
        sum      = s;
    endtask

    initial begin
        logic [9:0]  xb;
        logic [31:0] s;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // First sample after reset: single-cycle out_valid
        send(2'b00, 32'h0100_0000, 16'h1000, "relu_first");
        idle(32'h7FFF_FFFF);
        idle(32'h8000_0000);

        // ReLU
        send(2'b00, 32'h1000_0000, 16'h7FFF, "relu_sat");
        send(2'b00, 32'hFF00_0000, 16'h0000, "relu_neg");
        send(2'b00, 32'h7FFF_FFFF, 16'h7FFF, "relu_clamp_pos");
        send(2'b00, 32'h8000_0000, 16'h0000, "relu_clamp_neg");
        send(2'b00, 32'h0012_3456, 16'h0123, "relu_small");
        send(2'b00, 32'h07FF_FFFF, 16'h7FFF, "relu_max_fit");
        send(2'b00, 32'h0800_0000, 16'h7FFF, "relu_sat_edge");
        idle(32'h0000_0001);

        // Full-ROM sigmoid
        send(2'b01, 32'h0000_0000, 16'd2048, "sig_full_zero");
        send(2'b01, 32'h0100_0000, 16'd2994, "sig_full_pos1");
        send(2'b01, 32'hFF00_0000, 16'd1102, "sig_full_neg1");
        send(2'b01, 32'h7FFF_FFFF, 16'd4095, "sig_full_clamp_pos");
        send(2'b01, 32'h8000_0000, 16'd1,    "sig_full_clamp_neg");

        // Half-ROM sigmoid
        send(2'b10, 32'h0000_0000, 16'd2048, "sig_half_zero");
        send(2'b10, 32'h0100_0000, 16'd2994, "sig_half_pos1");
        send(2'b10, 32'hFF00_0000, 16'd1102, "sig_half_neg1");
        send(2'b10, 32'h7FFF_FFFF, 16'd4095, "sig_half_clamp_pos");
        send(2'b10, 32'h8000_0000, 16'd1,    "sig_half_clamp_neg");

        // Pass-through truncates
        send(2'b11, 32'h0100_0000, 16'h1000, "pass_pos");
        send(2'b11, 32'hFF00_0000, 16'hF000, "pass_neg");
        send(2'b11, 32'h7FFF_FFFF, 16'hFFFF, "pass_trunc");
        send(2'b11, 32'h0800_0000, 16'h8000, "pass_wrap");
        idle(32'h0100_0002);
        idle(32'hFFFF_FFFF);

        // Reset coinciding with a valid sample drops it; next sample is normal
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b1;
        act_sel  = 2'b00;
        sum      = 32'h0100_0000;
        send(2'b01, 32'h0100_0000, 16'd2994, "after_rst");
        rst = 1'b0;
        idle(32'h0);

        // Back-to-back with act_sel cycling
        send(2'b00, 32'h0100_0000, 16'h1000, "b2b_relu");
        send(2'b01, 32'h0100_0000, 16'h0BB2, "b2b_full");
        send(2'b10, 32'h0100_0000, 16'h0BB2, "b2b_half");
        send(2'b11, 32'h0100_0000, 16'h1000, "b2b_pass");
        idle(32'h0);

        // Sweep every sigmoid index in both sigmoid modes
        for (int x = -512; x < 512; x++) begin
            xb = 10'(x);
            s  = {{4{xb[9]}}, xb, 18'h2AAAA};
            send(2'b01, s, 16'(sig_e(x)),  "sweep_full");
            send(2'b10, s, 16'(half_e(x)), "sweep_half");
        end
        idle(32'h0);
        idle(32'h0);
        done = 1'b1;
    end

endmodule
